// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Done = 2'd2
  } state_e;

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sequencer.sv
// Feeds two operands LSB-first into an external one-bit adder, chaining the carry,
// and collects the sum bits into a result presented on a valid/ready handshake.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ADDER_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int unsigned IdxW = cnt_width(WIDTH);
  localparam int unsigned LatW = cnt_width(ADDER_LATENCY + 1);
  localparam logic [IdxW-1:0] BitMax = IdxW'(WIDTH - 1);
  localparam logic [LatW-1:0] LatMax = LatW'(ADDER_LATENCY);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_sh_q, res_sh_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic              add_a_q, add_b_q, add_cin_q;

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    carry_d   = carry_q;
    bit_idx_d = bit_idx_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      Idle: begin
        if (in_valid) begin
          a_sh_d    = in_a;
          b_sh_d    = in_b;
          carry_d   = in_cin;
          bit_idx_d = '0;
          lat_cnt_d = '0;
          state_d   = Run;
        end
      end
      Run: begin
        if (lat_cnt_q == LatMax) begin
          res_sh_d  = {add_sum, res_sh_q[WIDTH-1:1]};
          carry_d   = add_cout;
          a_sh_d    = a_sh_q >> 1;
          b_sh_d    = b_sh_q >> 1;
          lat_cnt_d = '0;
          bit_idx_d = bit_idx_q + IdxW'(1);
          if (bit_idx_q == BitMax) state_d = Done;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      Done: begin
        if (out_ready) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= Idle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_sh_q  <= '0;
      carry_q   <= 1'b0;
      bit_idx_q <= '0;
      lat_cnt_q <= '0;
      add_a_q   <= 1'b0;
      add_b_q   <= 1'b0;
      add_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_sh_q  <= res_sh_d;
      carry_q   <= carry_d;
      bit_idx_q <= bit_idx_d;
      lat_cnt_q <= lat_cnt_d;
      // Adder drive is flopped from next state so it cannot glitch mid-window.
      add_a_q   <= (state_d == Run) & a_sh_d[0];
      add_b_q   <= (state_d == Run) & b_sh_d[0];
      add_cin_q <= (state_d == Run) & carry_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign in_ready  = (state_q == Idle);
  assign out_valid = (state_q == Done);
  assign out_sum   = (state_q == Done) ? res_sh_q : '0;
  assign out_cout  = (state_q == Done) & carry_q;

endmodule
